// File: rtl/count_mon.sv
// Monitor for the 8-bit up/down counter: wrap pulses, a saturating wrap tally,
// and a debounced out-of-window alarm with acknowledge.
module count_mon #(
    parameter int HOLD = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [0:7] count_in,
    input  logic       ld_in,
    input  logic       mode_in,
    input  logic       en,
    input  logic       cfg_wr,
    input  logic [0:7] cfg_lo,
    input  logic [0:7] cfg_hi,
    input  logic       ack,
    input  logic       wrap_clr,
    output logic       ovf,
    output logic       unf,
    output logic [0:7] wrap_cnt,
    output logic       alarm,
    output logic       cfg_err,
    output logic [0:1] state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_PEND  = 2'b10,
        S_ALARM = 2'b11
    } state_t;

    localparam logic [3:0] HOLD_W = 4'(HOLD);

    logic [0:7] prev_q;
    logic [2:0] ctl_q;          // {ld, clr, mode} as seen in the previous cycle
    logic       ovf_q, ovf_d;
    logic       unf_q, unf_d;
    logic [0:7] wrap_q, wrap_d;
    logic [0:7] lo_q, lo_d;
    logic [0:7] hi_q, hi_d;
    logic       cfg_err_q, cfg_err_d;
    logic       alarm_q, alarm_d;
    state_t     state_q, state_d;
    logic [3:0] run_q, run_d;
    logic       wrap_ev;
    logic       oow;

    // A load or clear in the previous cycle means the count did not step, so no wrap.
    always_comb begin
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (!ctl_q[2] && !ctl_q[1]) begin
            ovf_d = ctl_q[0] && (prev_q == 8'hFF) && (count_in == 8'h00);
            unf_d = !ctl_q[0] && (prev_q == 8'h00) && (count_in == 8'hFF);
        end
        wrap_ev = ovf_d | unf_d;
    end

    always_comb begin
        wrap_d = wrap_q;
        if (wrap_clr) begin
            wrap_d = {7'd0, wrap_ev};
        end else if (wrap_ev && (wrap_q != 8'hFF)) begin
            wrap_d = wrap_q + 8'd1;
        end
    end

    always_comb begin
        lo_d      = cfg_wr ? cfg_lo : lo_q;
        hi_d      = cfg_wr ? cfg_hi : hi_q;
        cfg_err_d = (lo_d > hi_d);
        oow       = (count_in < lo_q) || (count_in > hi_q);
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (!en || cfg_err_q) begin
            state_d = S_IDLE;
            run_d   = 4'd0;
        end else if (cfg_wr && (state_q != S_IDLE)) begin
            state_d = S_ARMED;
            run_d   = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_ARMED;
                end
                S_ARMED: begin
                    if (oow) begin
                        run_d   = 4'd1;
                        state_d = (HOLD_W == 4'd1) ? S_ALARM : S_PEND;
                    end
                end
                S_PEND: begin
                    if (oow) begin
                        run_d = run_q + 4'd1;
                        if (run_q + 4'd1 == HOLD_W) begin
                            state_d = S_ALARM;
                        end
                    end else begin
                        state_d = S_ARMED;
                        run_d   = 4'd0;
                    end
                end
                S_ALARM: begin
                    if (ack && !oow) begin
                        state_d = S_ARMED;
                        run_d   = 4'd0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    run_d   = 4'd0;
                end
            endcase
        end
        alarm_d = (state_d == S_ALARM);
    end

    // Sample history is captured every edge, including the clear edge itself.
    always_ff @(posedge clk) begin
        prev_q <= count_in;
        ctl_q  <= {ld_in, clr, mode_in};
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            wrap_q    <= 8'h00;
            lo_q      <= 8'h00;
            hi_q      <= 8'hFF;
            cfg_err_q <= 1'b0;
            alarm_q   <= 1'b0;
            state_q   <= S_IDLE;
            run_q     <= 4'd0;
        end else begin
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            wrap_q    <= wrap_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            cfg_err_q <= cfg_err_d;
            alarm_q   <= alarm_d;
            state_q   <= state_d;
            run_q     <= run_d;
        end
    end

    assign ovf      = ovf_q;
    assign unf      = unf_q;
    assign wrap_cnt = wrap_q;
    assign alarm    = alarm_q;
    assign cfg_err  = cfg_err_q;
    assign state    = state_q;

endmodule

// File: tb/tb_count_mon.sv
// Directed bench for count_mon: the driver queues hand-computed expectations per
// cycle and a monitor pops and compares them just after each rising edge.
module tb_count_mon;

    logic       clk = 1'b0;
    logic       clr, ld_in, mode_in, en, cfg_wr, ack, wrap_clr;
    logic [0:7] count_in, cfg_lo, cfg_hi;
    logic       ovf, unf, alarm, cfg_err;
    logic [0:7] wrap_cnt;
    logic [0:1] state;

    int tests_run    = 0;
    int tests_failed = 0;

    // Entry layout: {mask[5:0], ovf, unf, wrap[7:0], alarm, err, state[1:0]}
    logic [19:0] exp_q[$];
    string       tag_q[$];

    localparam logic [5:0] M_OVF = 6'b100000, M_UNF = 6'b010000, M_WRAP = 6'b001000;
    localparam logic [5:0] M_AL  = 6'b000100, M_ERR = 6'b000010, M_ST   = 6'b000001;
    localparam logic [5:0] M_ALL = 6'b111111, M_FSM = M_AL | M_ST;
    localparam logic [1:0] IDLE = 2'b00, ARMED = 2'b01, PEND = 2'b10, ALRM = 2'b11;

    always #5 clk = ~clk;

    count_mon #(.HOLD(4)) dut (
        .clk(clk), .clr(clr), .count_in(count_in), .ld_in(ld_in), .mode_in(mode_in),
        .en(en), .cfg_wr(cfg_wr), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .ack(ack),
        .wrap_clr(wrap_clr), .ovf(ovf), .unf(unf), .wrap_cnt(wrap_cnt),
        .alarm(alarm), .cfg_err(cfg_err), .state(state)
    );

    task automatic drv(input logic c, input logic l, input logic md, input logic [7:0] cnt);
        clr      = c;
        ld_in    = l;
        mode_in  = md;
        count_in = cnt;
    endtask

    // Queue the outputs expected after the coming rising edge, then let the cycle run.
    task automatic cyc(input string tag, input logic [5:0] m, input logic e_ovf,
                       input logic e_unf, input logic [7:0] e_wrap, input logic e_alarm,
                       input logic e_err, input logic [1:0] e_state);
        exp_q.push_back({m, e_ovf, e_unf, e_wrap, e_alarm, e_err, e_state});
        tag_q.push_back(tag);
        @(negedge clk);
    endtask

    task automatic fsm(input string tag, input logic e_alarm, input logic [1:0] e_state);
        cyc(tag, M_FSM, 1'b0, 1'b0, 8'h00, e_alarm, 1'b0, e_state);
    endtask

    task automatic chk(input string tag, input string field, input logic [7:0] act,
                       input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s.%s: got %h, expected %h", tag, field, act, exp);
        end
    endtask

    initial begin : monitor
        logic [19:0] e;
        string       t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                if (e[19]) chk(t, "ovf",     {7'd0, ovf},     {7'd0, e[13]});
                if (e[18]) chk(t, "unf",     {7'd0, unf},     {7'd0, e[12]});
                if (e[17]) chk(t, "wrap",    wrap_cnt,        e[11:4]);
                if (e[16]) chk(t, "alarm",   {7'd0, alarm},   {7'd0, e[3]});
                if (e[15]) chk(t, "cfg_err", {7'd0, cfg_err}, {7'd0, e[2]});
                if (e[14]) chk(t, "state",   {6'd0, state},   {6'd0, e[1:0]});
            end
        end
    end

    initial begin : driver
        int e;
        en = 1'b0; cfg_wr = 1'b0; cfg_lo = 8'h00; cfg_hi = 8'h00; ack = 1'b0; wrap_clr = 1'b0;

        drv(1, 0, 1, 8'h00); cyc("reset", M_ALL, 0, 0, 8'h00, 0, 0, IDLE);

        // Up wrap FE -> FF -> 00 -> 01 after a load
        drv(0, 1, 1, 8'h00); cyc("up_ld",    M_OVF | M_UNF | M_WRAP, 0, 0, 8'h00, 0, 0, IDLE);
        drv(0, 0, 1, 8'hFE); cyc("up_fe",    M_OVF | M_UNF | M_WRAP, 0, 0, 8'h00, 0, 0, IDLE);
        drv(0, 0, 1, 8'hFF); cyc("up_ff",    M_OVF | M_UNF | M_WRAP, 0, 0, 8'h00, 0, 0, IDLE);
        drv(0, 0, 1, 8'h00); cyc("up_wrap",  M_OVF | M_UNF | M_WRAP, 1, 0, 8'h01, 0, 0, IDLE);
        drv(0, 0, 1, 8'h01); cyc("up_after", M_OVF | M_UNF | M_WRAP, 0, 0, 8'h01, 0, 0, IDLE);

        // Down wrap 01 -> 00 -> FF
        drv(0, 0, 0, 8'h01); cyc("dn_01",    M_OVF | M_UNF | M_WRAP, 0, 0, 8'h01, 0, 0, IDLE);
        drv(0, 0, 0, 8'h00); cyc("dn_00",    M_OVF | M_UNF | M_WRAP, 0, 0, 8'h01, 0, 0, IDLE);
        drv(0, 0, 0, 8'hFF); cyc("dn_wrap",  M_OVF | M_UNF | M_WRAP, 0, 1, 8'h02, 0, 0, IDLE);
        drv(0, 0, 0, 8'hFE); cyc("dn_after", M_OVF | M_UNF | M_WRAP, 0, 0, 8'h02, 0, 0, IDLE);

        // Load of 00 right after FF must not count as an overflow
        drv(0, 1, 1, 8'hFF); cyc("ld_ff",  M_OVF | M_UNF | M_WRAP, 0, 0, 8'h02, 0, 0, IDLE);
        drv(0, 0, 1, 8'h00); cyc("ld_sup", M_OVF | M_UNF | M_WRAP, 0, 0, 8'h02, 0, 0, IDLE);

        // 260 further wraps: tally climbs from 2 and sticks at FF
        for (int i = 0; i < 260; i++) begin
            drv(0, 0, 1, 8'hFF); cyc("sat_ff", M_UNF, 0, 0, 8'h00, 0, 0, IDLE);
            e = i + 3;
            if (e > 255) e = 255;
            drv(0, 0, 1, 8'h00); cyc("sat_wrap", M_OVF | M_WRAP, 1, 0, 8'(e), 0, 0, IDLE);
        end

        // wrap_clr colliding with an event keeps the event
        drv(0, 0, 1, 8'hFF); cyc("col_ff", M_WRAP, 0, 0, 8'hFF, 0, 0, IDLE);
        wrap_clr = 1'b1;
        drv(0, 0, 1, 8'h00); cyc("col_wrap", M_OVF | M_WRAP, 1, 0, 8'h01, 0, 0, IDLE);
        drv(0, 0, 1, 8'h01); cyc("clr_only", M_OVF | M_WRAP, 0, 0, 8'h00, 0, 0, IDLE);
        wrap_clr = 1'b0;

        // Window 10..20, HOLD=4
        cfg_wr = 1'b1; cfg_lo = 8'h10; cfg_hi = 8'h20;
        drv(0, 0, 1, 8'h18); cyc("cfg_win", M_ERR | M_FSM, 0, 0, 8'h00, 0, 0, IDLE);
        cfg_wr = 1'b0; en = 1'b1;
        fsm("arm", 0, ARMED);
        drv(0, 0, 1, 8'h25);
        fsm("oow1", 0, PEND); fsm("oow2", 0, PEND); fsm("oow3", 0, PEND);
        drv(0, 0, 1, 8'h18); fsm("back_in", 0, ARMED);
        drv(0, 0, 1, 8'h25);
        fsm("hold1", 0, PEND); fsm("hold2", 0, PEND); fsm("hold3", 0, PEND);
        fsm("hold4", 1, ALRM);

        // Acknowledge only counts together with in-window
        ack = 1'b1; fsm("ack_oow", 1, ALRM);
        ack = 1'b0; fsm("stay_alarm", 1, ALRM);
        ack = 1'b1; drv(0, 0, 1, 8'h15); fsm("ack_in", 0, ARMED);
        drv(0, 0, 1, 8'h25); fsm("ack_armed", 0, PEND);
        ack = 1'b0;
        drv(0, 0, 1, 8'h18); fsm("rearm", 0, ARMED);

        // Window limits are inclusive
        drv(0, 0, 1, 8'h20); fsm("at_hi", 0, ARMED);
        drv(0, 0, 1, 8'h10); fsm("at_lo", 0, ARMED);
        drv(0, 0, 1, 8'h21); fsm("above_hi", 0, PEND);
        drv(0, 0, 1, 8'h0F); fsm("below_lo", 0, PEND);
        drv(0, 0, 1, 8'h10); fsm("lo_again", 0, ARMED);

        // Inverted limits: cfg_wr re-arms first, then the registered error forces IDLE
        cfg_wr = 1'b1; cfg_lo = 8'h30; cfg_hi = 8'h20;
        drv(0, 0, 1, 8'h15); cyc("err_set", M_ERR | M_ST, 0, 0, 8'h00, 0, 1, ARMED);
        cfg_wr = 1'b0;
        cyc("err_idle", M_ERR | M_FSM, 0, 0, 8'h00, 0, 1, IDLE);
        cyc("err_hold", M_ERR | M_FSM, 0, 0, 8'h00, 0, 1, IDLE);
        cfg_wr = 1'b1; cfg_lo = 8'h10; cfg_hi = 8'h20;
        cyc("err_fix", M_ERR | M_FSM, 0, 0, 8'h00, 0, 0, IDLE);
        cfg_wr = 1'b0; en = 1'b0;

        // Wrap while idle, then climb back into ALARM
        drv(0, 0, 1, 8'hFF); cyc("idle_ff",   M_OVF | M_WRAP | M_ST, 0, 0, 8'h00, 0, 0, IDLE);
        drv(0, 0, 1, 8'h00); cyc("idle_wrap", M_OVF | M_WRAP | M_ST, 1, 0, 8'h01, 0, 0, IDLE);
        en = 1'b1;
        drv(0, 0, 1, 8'h18); cyc("re_arm", M_OVF | M_WRAP | M_ST, 0, 0, 8'h01, 0, 0, ARMED);
        drv(0, 0, 1, 8'h25);
        fsm("re1", 0, PEND); fsm("re2", 0, PEND); fsm("re3", 0, PEND); fsm("re4", 1, ALRM);

        // Clear mid-alarm, then the first cycle after clear must not detect FF -> 00
        drv(1, 0, 1, 8'hFF); cyc("clr_alarm", M_ALL, 0, 0, 8'h00, 0, 0, IDLE);
        drv(0, 0, 1, 8'h00); cyc("post_clr", M_ALL, 0, 0, 8'h00, 0, 0, ARMED);
        drv(0, 0, 1, 8'h25);
        for (int i = 0; i < 5; i++) fsm("default_win", 0, ARMED);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
